t01_piece_queue: RTL and testbench
==================================

// Module: t01_piece_queue
// PURPOSE
//  Consumer side of the t01 block-type generator (LFSR counter): pulls block types, buffers the
//  upcoming pieces, and hands the head piece to the game FSM on spawn. Drives the generator's
//  enable (gen_advance), so the generator steps only when a type is actually consumed. Also
//  feeds the next-piece preview for the display path.
// PARAMETERS
//  DEPTH    4  queue entries incl. head; legal 2..8
//  WARMUP   3  generator samples discarded after reset/flush before the first push; legal 0..15
// PORTS
//  clk            in   1            system clock, all logic on posedge
//  rst            in   1            synchronous, active-high reset
//  block_type_in  in   3            generator output, combinational from current LFSR state, 0..6
//  gen_advance    out  1            generator enable; 1 = type sampled/consumed this cycle
//  flush          in   1            new game: empty queue, re-enter warm-up
//  pop            in   1            spawn request; consumes head when piece_valid
//  piece_valid    out  1            head entry valid
//  piece_type     out  3            head entry type (0 when !piece_valid)
//  preview        out  3*(DEPTH-1)  entries 1..DEPTH-1; entry k at [3k-1:3k-3]; invalid slots read 0
//  count          out  4            valid entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=WARMUP, warm-up counter=0, all entries=0, count=0;
//    outputs piece_valid=0, piece_type=0, preview=0, gen_advance=0 during the reset cycle.
//  - gen_advance is combinational from state/count/pop; sampling block_type_in and asserting
//    gen_advance happen in the same cycle, so the next cycle presents the following type.
//  - States:
//    WARMUP: gen_advance=1 each cycle, sample discarded; after WARMUP samples -> FILL
//            (WARMUP=0: go straight to FILL the cycle after reset).
//    FILL:   count<DEPTH: gen_advance=1, sample pushed at tail, count+1; count reaches DEPTH -> READY.
//            A pop in FILL with count>=1 is honoured: head removed, and the push still happens
//            in the same cycle (net count unchanged).
//    READY:  gen_advance=pop. On pop: entries shift toward head by one, sample written at
//            tail, count stays DEPTH. No pop: hold, gen_advance=0.
//  - Zero latency on pop: the new head appears on piece_type the cycle after the pop edge.
//  - pop with count=0: ignored, no state change.
//  - pop during WARMUP: ignored.
//  - flush (any state, priority over pop): entries=0, count=0, warm-up counter=0, state=WARMUP
//    next cycle; gen_advance=0 in the flush cycle.
//  - rst has priority over flush and pop.
//  - Types >=7 on block_type_in are illegal; the queue masks a 7 to 0 on entry, no error flag.
//  - count is never <0 or >DEPTH; no overflow path exists, since a push occurs only when a slot is
//    free or is freed the same cycle.
// CONFIGURATION
//  T01_PIECE_QUEUE_REROLL_EN
//   defined: a sample equal to the type most recently pushed is rejected once. gen_advance=1,
//            nothing pushed, a reroll flag is set; the next sample is pushed unconditionally and
//            the flag clears. In READY, a rejected pop-refill leaves count=DEPTH-1, state=FILL,
//            refilled next cycle. Last-pushed register and flag clear on rst/flush.
//   undefined: every sample outside WARMUP is pushed; no last-pushed register.
// TESTING (stub drives block_type_in from a scripted sequence, DEPTH=4, WARMUP=3)
//  1. Reset, sequence 5,5,5,1,2,3,4,6 -> 3 samples dropped; count 1..4 over 4 cycles;
//     head=1, preview={4,3,2}; gen_advance low once READY.
//  2. READY, single pop with input 6 -> next cycle head=2, preview={6,4,3}, count=4,
//     gen_advance=1 only in the pop cycle.
//  3. Pop every cycle for 10 cycles -> head follows input delayed by 4 pops; count stays 4;
//     gen_advance=1 all 10 cycles.
//  4. flush asserted together with pop in READY -> next cycle count=0, piece_valid=0,
//     piece_type=0, pop not consumed; warm-up re-run (3 gen_advance pulses) before pushing.
//  5. rst during FILL with count=2 -> next cycle count=0, state WARMUP; block_type_in=7 later
//     enters the queue as 0.
//  6. REROLL_EN, last pushed=3, input 3 then 3 -> first 3 rejected (count unchanged, gen_advance=1),
//     second 3 pushed; without the macro both are pushed.

Source files
------------

// File: rtl/t01_piece_queue.sv
// Piece queue for the t01 block-type generator: warm-up, fill, then refill-on-pop with preview.
// Optional T01_PIECE_QUEUE_REROLL_EN rejects a sample equal to the last pushed type once.
module t01_piece_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WARMUP = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2:0]             block_type_i,
    output logic                   gen_advance_o,
    input  logic                   flush_i,
    input  logic                   pop_i,
    output logic                   piece_valid_o,
    output logic [2:0]             piece_type_o,
    output logic [3*(DEPTH-1)-1:0] preview_o,
    output logic [3:0]             count_o
);

    typedef enum logic [1:0] {StWarmup, StFill, StReady} state_e;

    // With no warm-up samples the queue starts filling straight out of reset/flush.
    localparam state_e StInit = (WARMUP == 0) ? StFill : StWarmup;
    localparam logic [3:0] DepthCnt = 4'(DEPTH);
    localparam logic [3:0] WarmCnt  = 4'(WARMUP);

    state_e     st_q, st_d;
    logic [3:0] warm_q, warm_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] ent_q [DEPTH];
    logic [2:0] ent_d [DEPTH];

    logic [2:0] sample;
    logic       adv;
    logic       pop_ok;
    logic       push_req;
    logic       push;
    logic [3:0] cnt_after_pop;

    assign sample = (block_type_i == 3'd7) ? 3'd0 : block_type_i;

    always_comb begin
        adv      = 1'b0;
        pop_ok   = 1'b0;
        push_req = 1'b0;
        unique case (st_q)
            StWarmup: adv = 1'b1;
            StFill: begin
                adv      = 1'b1;
                push_req = 1'b1;
                pop_ok   = pop_i && (cnt_q != 4'd0);
            end
            StReady: begin
                adv      = pop_i;
                push_req = pop_i;
                pop_ok   = pop_i;
            end
            default: ;
        endcase
        if (flush_i) begin
            adv      = 1'b0;
            pop_ok   = 1'b0;
            push_req = 1'b0;
        end
    end

`ifdef T01_PIECE_QUEUE_REROLL_EN
    logic [2:0] last_q, last_d;
    logic       last_vld_q, last_vld_d;
    logic       reroll_q, reroll_d;
    logic       reject;

    assign reject = push_req && last_vld_q && !reroll_q && (sample == last_q);
    assign push   = push_req && !reject;

    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        reroll_d   = reroll_q;
        if (flush_i) begin
            last_d     = 3'd0;
            last_vld_d = 1'b0;
            reroll_d   = 1'b0;
        end else if (reject) begin
            reroll_d = 1'b1;
        end else if (push) begin
            last_d     = sample;
            last_vld_d = 1'b1;
            reroll_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q     <= 3'd0;
            last_vld_q <= 1'b0;
            reroll_q   <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            reroll_q   <= reroll_d;
        end
    end
`else
    assign push = push_req;
`endif

    always_comb begin
        st_d          = st_q;
        warm_d        = warm_q;
        cnt_d         = cnt_q;
        ent_d         = ent_q;
        cnt_after_pop = cnt_q;
        if (flush_i) begin
            st_d   = StInit;
            warm_d = 4'd0;
            cnt_d  = 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = 3'd0;
            end
        end else begin
            if (st_q == StWarmup) begin
                warm_d = warm_q + 4'd1;
                if (warm_q + 4'd1 >= WarmCnt) begin
                    st_d = StFill;
                end
            end
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    ent_d[i] = ent_q[i+1];
                end
                ent_d[DEPTH-1] = 3'd0;
                cnt_after_pop  = cnt_q - 4'd1;
            end
            // Tail slot is the first free entry after any same-cycle pop.
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (4'(i) == cnt_after_pop) begin
                        ent_d[i] = sample;
                    end
                end
                cnt_d = cnt_after_pop + 4'd1;
            end else begin
                cnt_d = cnt_after_pop;
            end
            if (st_q != StWarmup) begin
                st_d = (cnt_d == DepthCnt) ? StReady : StFill;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q   <= StInit;
            warm_q <= 4'd0;
            cnt_q  <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= 3'd0;
            end
        end else begin
            st_q   <= st_d;
            warm_q <= warm_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Outputs read zero while reset is being applied.
    assign gen_advance_o = adv && !rst_i;
    assign piece_valid_o = !rst_i && (cnt_q != 4'd0);
    assign piece_type_o  = piece_valid_o ? ent_q[0] : 3'd0;
    assign count_o       = rst_i ? 4'd0 : cnt_q;

    always_comb begin
        preview_o = '0;
        for (int k = 1; k < DEPTH; k++) begin
            preview_o[3*k-1 -: 3] = rst_i ? 3'd0 : ent_q[k];
        end
    end

endmodule

// File: tb/tb_t01_piece_queue.sv
// Directed bench for t01_piece_queue (DEPTH=4, WARMUP=3) with a scripted generator stub.
module tb_t01_piece_queue;

    logic       clk;
    logic       rst;
    logic [2:0] block_type;
    logic       gen_advance;
    logic       flush;
    logic       pop;
    logic       piece_valid;
    logic [2:0] piece_type;
    logic [8:0] preview;
    logic [3:0] count;

    int         n_total = 0;
    int         n_bad   = 0;
    int         idx     = 0;
    logic [2:0] seq [64];
    int         exp_head3 [10];

    t01_piece_queue #(
        .DEPTH  (4),
        .WARMUP (3)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .block_type_i  (block_type),
        .gen_advance_o (gen_advance),
        .flush_i       (flush),
        .pop_i         (pop),
        .piece_valid_o (piece_valid),
        .piece_type_o  (piece_type),
        .preview_o     (preview),
        .count_o       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Stub generator: steps to the next scripted type whenever gen_advance was high at the edge.
    task automatic clk_cycle();
        logic adv_seen;
        #1;
        adv_seen = gen_advance;
        @(posedge clk);
        #1;
        if (adv_seen) idx++;
        block_type = seq[idx];
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) seq[i] = 3'd0;
        seq[0] = 3'd5; seq[1] = 3'd5; seq[2] = 3'd5; seq[3] = 3'd1;
        seq[4] = 3'd2; seq[5] = 3'd3; seq[6] = 3'd4; seq[7] = 3'd6;
        for (int i = 0; i < 10; i++) seq[8+i] = 3'(i % 7);
        seq[18] = 3'd7; seq[19] = 3'd7; seq[20] = 3'd7;
        seq[21] = 3'd3; seq[22] = 3'd5;
        seq[23] = 3'd1; seq[24] = 3'd1; seq[25] = 3'd1;
        seq[26] = 3'd7; seq[27] = 3'd4; seq[28] = 3'd3; seq[29] = 3'd3; seq[30] = 3'd3;
        exp_head3 = '{3, 4, 6, 0, 1, 2, 3, 4, 5, 6};

        rst = 1'b1; flush = 1'b0; pop = 1'b0; block_type = seq[0];
        #2;
        check_eq("rst_adv", int'(gen_advance), 0);
        check_eq("rst_valid", int'(piece_valid), 0);
        clk_cycle();
        rst = 1'b0;
        #1;
        check_eq("post_rst_count", int'(count), 0);
        check_eq("warm_adv", int'(gen_advance), 1);

        // 1: warm-up drops three samples, then fill 1..4
        for (int i = 0; i < 3; i++) clk_cycle();
        check_eq("warm_count", int'(count), 0);
        check_eq("warm_idx", idx, 3);
        for (int i = 1; i <= 4; i++) begin
            clk_cycle();
            check_eq("fill_count", int'(count), i);
        end
        check_eq("t1_valid", int'(piece_valid), 1);
        check_eq("t1_head", int'(piece_type), 1);
        check_eq("t1_preview", int'(preview), 9'h11A);
        check_eq("t1_ready_adv", int'(gen_advance), 0);

        // 2: single pop with input 6
        pop = 1'b1;
        #1;
        check_eq("t2_pop_adv", int'(gen_advance), 1);
        clk_cycle();
        pop = 1'b0;
        #1;
        check_eq("t2_head", int'(piece_type), 2);
        check_eq("t2_preview", int'(preview), 9'h1A3);
        check_eq("t2_count", int'(count), 4);
        check_eq("t2_adv", int'(gen_advance), 0);

        // 3: pop every cycle for 10 cycles
        pop = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #1;
            check_eq("t3_adv", int'(gen_advance), 1);
            clk_cycle();
            check_eq("t3_head", int'(piece_type), exp_head3[j]);
            check_eq("t3_count", int'(count), 4);
        end
        check_eq("t3_preview", int'(preview), 9'h088);

        // 4: flush with pop in READY
        flush = 1'b1;
        #1;
        check_eq("t4_flush_adv", int'(gen_advance), 0);
        clk_cycle();
        flush = 1'b0; pop = 1'b0;
        #1;
        check_eq("t4_count", int'(count), 0);
        check_eq("t4_valid", int'(piece_valid), 0);
        check_eq("t4_type", int'(piece_type), 0);
        check_eq("t4_idx", idx, 18);
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_warm_adv", int'(gen_advance), 1);
            clk_cycle();
            check_eq("t4_warm_count", int'(count), 0);
        end
        clk_cycle();
        clk_cycle();
        check_eq("t5_fill2", int'(count), 2);
        check_eq("t5_head", int'(piece_type), 3);

        // 5: reset during FILL, then a 7 enters as 0
        rst = 1'b1;
        #1;
        check_eq("t5_rst_adv", int'(gen_advance), 0);
        clk_cycle();
        rst = 1'b0;
        #1;
        check_eq("t5_count", int'(count), 0);
        check_eq("t5_valid", int'(piece_valid), 0);
        for (int i = 0; i < 3; i++) clk_cycle();
        check_eq("t5_idx", idx, 26);
        clk_cycle();
        check_eq("t5_mask_count", int'(count), 1);
        check_eq("t5_mask_valid", int'(piece_valid), 1);
        check_eq("t5_mask_head", int'(piece_type), 0);
        clk_cycle();
        check_eq("t5_prev1", int'(preview[2:0]), 4);
        clk_cycle();
        check_eq("t6_count3", int'(count), 3);

        // 6: last pushed 3, then inputs 3, 3
        clk_cycle();
`ifdef T01_PIECE_QUEUE_REROLL_EN
        check_eq("t6_reject_count", int'(count), 3);
        check_eq("t6_reject_adv", int'(gen_advance), 1);
`else
        check_eq("t6_push_count", int'(count), 4);
        check_eq("t6_ready_adv", int'(gen_advance), 0);
`endif
        clk_cycle();
        check_eq("t6_count4", int'(count), 4);
        check_eq("t6_preview", int'(preview), 9'h0DC);
`ifdef T01_PIECE_QUEUE_REROLL_EN
        check_eq("t6_idx", idx, 31);
`else
        check_eq("t6_idx", idx, 30);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
